ucb_scheduler: RTL and testbench

Sequencer sitting between the unsat clause buffers (UCBs) and a pool of clause_register engines in the WalkSAT core. Arbitrates round-robin among UCB requesters, hands each granted 36-bit clause to the lowest-index free engine, tracks engine reservations, and totals flips reported by the engines. Also owns run/stop sequencing: start, drain and done.

---
 rtl/wsat_pkg.sv | 23 ++
 rtl/ucb_scheduler_rr_arbiter.sv | 24 ++
 rtl/ucb_scheduler.sv | 154 +++++++++++++++
 tb/tb_ucb_scheduler.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wsat_pkg.sv
// Shared WalkSAT core types: clause/flip widths, literal field layout, scheduler states.
// Literal k occupies [LITk_LSB +: LIT_W]; its top bit is the negation flag.
package wsat_pkg;

   localparam int CLAUSE_W = 36;
   localparam int FLIP_W   = 21;
   localparam int LIT_W    = 12;

   localparam int LIT1_LSB = 0;
   localparam int LIT2_LSB = 12;
   localparam int LIT3_LSB = 24;
   localparam int LIT1_NEG = 11;
   localparam int LIT2_NEG = 23;
   localparam int LIT3_NEG = 35;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_DRAIN = 2'b10,
      S_DONE  = 2'b11
   } sched_state_t;

endpackage

// File: rtl/ucb_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr, wrapping.
// Zero latency; the pointer is owned and advanced by the instantiating block.
module rr_arbiter #(
   parameter int N = 4,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic          any
);

   always_comb begin
      gnt = '0;
      any = 1'b0;
      for (int off = 0; off < N; off++) begin
         if (!any && req[(int'(ptr) + off) % N]) begin
            gnt[(int'(ptr) + off) % N] = 1'b1;
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ucb_scheduler.sv
// Hands UCB head clauses round-robin to the lowest free engine, totals flips, sequences run/drain/done.
// Grant is combinational, eng_valid one cycle later; UCB_SCHED_FLIP_LIMIT_EN adds a flip budget.
module ucb_scheduler
   import wsat_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int NUM_ENG  = 2,
   parameter int CLAUSE_W = wsat_pkg::CLAUSE_W,
   parameter int FLIP_W   = wsat_pkg::FLIP_W
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic                        stop,
   input  logic [NUM_REQ-1:0]          ucb_req,
   input  logic [NUM_REQ*CLAUSE_W-1:0] ucb_data,
   output logic [NUM_REQ-1:0]          ucb_gnt,
   input  logic [NUM_ENG-1:0]          eng_idle,
   input  logic [NUM_ENG-1:0]          eng_flip,
   output logic [NUM_ENG-1:0]          eng_valid,
   output logic [NUM_ENG*CLAUSE_W-1:0] eng_clause,
   output logic [FLIP_W-1:0]           flip_total,
   output logic [1:0]                  sched_state,
   output logic                        done
`ifdef UCB_SCHED_FLIP_LIMIT_EN
   ,
   input  logic [FLIP_W-1:0]           max_flips
`endif
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [FLIP_W:0] FLIP_MAX = {1'b0, {FLIP_W{1'b1}}};

   sched_state_t                state_q, state_d;
   logic [PW-1:0]               rr_ptr_q, rr_ptr_d;
   logic [NUM_ENG-1:0]          reserved_q, reserved_d;
   logic [NUM_ENG-1:0]          eng_valid_q, eng_valid_d;
   logic [NUM_ENG*CLAUSE_W-1:0] eng_clause_q, eng_clause_d;
   logic [FLIP_W-1:0]           flip_total_q, flip_total_d;

   logic [NUM_REQ-1:0]  arb_gnt;
   logic                arb_any;
   logic [NUM_ENG-1:0]  free_eng;
   logic [NUM_ENG-1:0]  tgt_eng;
   logic [NUM_ENG-1:0]  load;
   logic                grant_en;
   logic [CLAUSE_W-1:0] gnt_data;
   logic [FLIP_W:0]     flip_add;
   logic [FLIP_W:0]     flip_sum;
   logic [FLIP_W-1:0]   flip_sat;
   logic                budget_hit;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req (ucb_req),
      .ptr (rr_ptr_q),
      .gnt (arb_gnt),
      .any (arb_any)
   );

   // An engine is free only once its reservation has been released by it going busy.
   always_comb begin
      free_eng = eng_idle & ~reserved_q;
      tgt_eng  = '0;
      for (int e = NUM_ENG - 1; e >= 0; e--) begin
         if (free_eng[e]) begin
            tgt_eng    = '0;
            tgt_eng[e] = 1'b1;
         end
      end
      grant_en = (state_q == S_RUN) && (|free_eng) && arb_any;
      ucb_gnt  = grant_en ? arb_gnt : '0;
      load     = grant_en ? tgt_eng : '0;

      gnt_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_gnt[i]) gnt_data = ucb_data[i*CLAUSE_W +: CLAUSE_W];
      end
   end

   always_comb begin
      flip_add = '0;
      for (int e = 0; e < NUM_ENG; e++) begin
         flip_add = flip_add + (FLIP_W + 1)'(eng_flip[e]);
      end
      flip_sum = {1'b0, flip_total_q} + flip_add;
      flip_sat = (flip_sum > FLIP_MAX) ? {FLIP_W{1'b1}} : flip_sum[FLIP_W-1:0];
`ifdef UCB_SCHED_FLIP_LIMIT_EN
      budget_hit = (max_flips != '0) && (flip_sat >= max_flips);
`else
      budget_hit = 1'b0;
`endif
   end

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      reserved_d   = (reserved_q & eng_idle) | load;
      eng_valid_d  = load;
      eng_clause_d = eng_clause_q;
      flip_total_d = flip_total_q;

      for (int i = 0; i < NUM_REQ; i++) begin
         if (ucb_gnt[i]) rr_ptr_d = PW'((i + 1) % NUM_REQ);
      end
      for (int e = 0; e < NUM_ENG; e++) begin
         if (load[e]) eng_clause_d[e*CLAUSE_W +: CLAUSE_W] = gnt_data;
      end

      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d      = S_RUN;
               rr_ptr_d     = '0;
               reserved_d   = '0;
               flip_total_d = '0;
            end
         end
         S_RUN: begin
            flip_total_d = flip_sat;
            if (stop || budget_hit) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            flip_total_d = flip_sat;
            if ((&eng_idle) && (reserved_q == '0)) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         rr_ptr_q     <= '0;
         reserved_q   <= '0;
         eng_valid_q  <= '0;
         eng_clause_q <= '0;
         flip_total_q <= '0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         reserved_q   <= reserved_d;
         eng_valid_q  <= eng_valid_d;
         eng_clause_q <= eng_clause_d;
         flip_total_q <= flip_total_d;
      end
   end

   assign eng_valid   = eng_valid_q;
   assign eng_clause  = eng_clause_q;
   assign flip_total  = flip_total_q;
   assign sched_state = state_q;
   assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_ucb_scheduler.sv
// Directed bench for ucb_scheduler with a small behavioural engine model (busy 3 cycles after each load).
// FLIP_W is reduced to 3 so saturation is reachable; budget test runs when UCB_SCHED_FLIP_LIMIT_EN is defined.
module tb_ucb_scheduler;

   localparam int NR = 4;
   localparam int NE = 2;
   localparam int CW = 36;
   localparam int FW = 3;

   localparam logic [CW-1:0] D0 = 36'h8ABC0DEF1;
   localparam logic [CW-1:0] D1 = 36'h123456789;
   localparam logic [CW-1:0] D2 = 36'hFEDCBA987;
   localparam logic [CW-1:0] D3 = 36'h0F0F0F0F0;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic             stop;
   logic [NR-1:0]    ucb_req;
   logic [NR*CW-1:0] ucb_data;
   logic [NR-1:0]    ucb_gnt;
   logic [NE-1:0]    eng_idle = '1;
   logic [NE-1:0]    eng_flip;
   logic [NE-1:0]    eng_valid;
   logic [NE*CW-1:0] eng_clause;
   logic [FW-1:0]    flip_total;
   logic [1:0]       sched_state;
   logic             done;
`ifdef UCB_SCHED_FLIP_LIMIT_EN
   logic [FW-1:0]    max_flips = '0;
`endif

   int errors = 0;
   int checks = 0;

   ucb_scheduler #(
      .NUM_REQ(NR), .NUM_ENG(NE), .CLAUSE_W(CW), .FLIP_W(FW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
      .ucb_req(ucb_req), .ucb_data(ucb_data), .ucb_gnt(ucb_gnt),
      .eng_idle(eng_idle), .eng_flip(eng_flip),
      .eng_valid(eng_valid), .eng_clause(eng_clause),
      .flip_total(flip_total), .sched_state(sched_state), .done(done)
`ifdef UCB_SCHED_FLIP_LIMIT_EN
      , .max_flips(max_flips)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!done && n < 30) begin
         tick();
         n++;
      end
      chk(tag, done, 1);
   endtask

   // Engine model: goes busy the cycle after its load strobe, idle again 3 cycles later.
   logic [NE-1:0] pend = '0;
   int busy_cnt [NE];
   always @(posedge clk) begin
      #1;
      for (int e = 0; e < NE; e++) begin
         if (!rst_n) begin
            eng_idle[e] = 1'b1;
            pend[e]     = 1'b0;
            busy_cnt[e] = 0;
         end else begin
            if (pend[e]) begin
               eng_idle[e] = 1'b0;
               busy_cnt[e] = 3;
               pend[e]     = 1'b0;
            end else if (busy_cnt[e] > 0) begin
               busy_cnt[e]--;
               if (busy_cnt[e] == 0) eng_idle[e] = 1'b1;
            end
            if (eng_valid[e]) begin
               chk("load_only_free_engine", eng_idle[e], 1);
               pend[e] = 1'b1;
            end
         end
      end
   end

   int            gq[$];
   logic [NE-1:0] vq[$];
   int            exp_g [4] = '{0, 2, 0, 2};
   logic [NE-1:0] exp_v [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      stop     = 1'b0;
      ucb_req  = '1;
      ucb_data = {D3, D2, D1, D0};
      eng_flip = '0;
      repeat (3) tick();
      #1;
      chk("rst_gnt", ucb_gnt, 0);
      chk("rst_valid", eng_valid, 0);
      chk("rst_clause", eng_clause, 0);
      chk("rst_flip", flip_total, 0);
      chk("rst_state", sched_state, 0);
      chk("rst_done", done, 0);

      // IDLE: stop ignored, flips frozen
      rst_n   = 1'b1;
      ucb_req = '0;
      stop    = 1'b1;
      eng_flip = 2'b11;
      tick();
      stop    = 1'b0;
      eng_flip = '0;
      chk("idle_ignores_stop", sched_state, 0);
      chk("idle_flip_frozen", flip_total, 0);

      // Consecutive grants to requesters 0,1 landing on engines 0,1
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_to_run", sched_state, 1);
      ucb_req = '1;
      #1;
      chk("gnt_first", ucb_gnt, 4'b0001);
      tick();
      chk("valid_e0", eng_valid, 2'b01);
      chk("clause_e0", eng_clause[CW-1:0], D0);
      #1;
      chk("gnt_second", ucb_gnt, 4'b0010);
      tick();
      chk("no_regrant_e0", eng_valid, 2'b10);
      chk("clause_e1", eng_clause[2*CW-1:CW], D1);
      chk("clause_e0_held", eng_clause[CW-1:0], D0);
      #1;
      chk("gnt_none_free", ucb_gnt, 0);
      ucb_req = '0;

      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("stop_to_drain", sched_state, 2);
      wait_done("drain_to_done_1");
      chk("done_state", sched_state, 3);
      ucb_req = '1;
      #1;
      chk("done_no_gnt", ucb_gnt, 0);
      ucb_req = '0;
      eng_flip = 2'b11;
      tick();
      eng_flip = '0;
      chk("done_flip_frozen", flip_total, 0);

      // Round-robin between requesters 0 and 2 with engines cycling
      start = 1'b1;
      tick();
      start = 1'b0;
      ucb_req = 4'b0101;
      for (int n = 0; n < 60 && gq.size() < 4; n++) begin
         if (eng_valid != '0) vq.push_back(eng_valid);
         #1;
         for (int i = 0; i < NR; i++) if (ucb_gnt[i]) gq.push_back(i);
         tick();
      end
      if (eng_valid != '0) vq.push_back(eng_valid);
      ucb_req = '0;
      chk("rr_grant_count", gq.size(), 4);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("rr_order_%0d", k), (k < gq.size()) ? gq[k] : 99, exp_g[k]);
         chk($sformatf("rr_engine_%0d", k), (k < vq.size()) ? vq[k] : 2'b00, exp_v[k]);
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_done("drain_to_done_2");

      // Flip counting and saturation at 7
      start = 1'b1;
      tick();
      start = 1'b0;
      eng_flip = 2'b11;
      tick(); chk("flip_2", flip_total, 2);
      tick(); chk("flip_4", flip_total, 4);
      tick(); chk("flip_6", flip_total, 6);
      tick(); chk("flip_sat", flip_total, 7);
      tick(); chk("flip_sat_hold", flip_total, 7);
      eng_flip = '0;
      chk("unlimited_stays_run", sched_state, 1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_done("drain_to_done_3");

      // Budget of 5 (only effective with the flip-limit build)
`ifdef UCB_SCHED_FLIP_LIMIT_EN
      max_flips = 3'd5;
`endif
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("flip_clear_on_start", flip_total, 0);
      eng_flip = 2'b01;
      repeat (4) tick();
      chk("flip_4_single", flip_total, 4);
      chk("below_budget_run", sched_state, 1);
      tick();
      eng_flip = '0;
      chk("flip_5_single", flip_total, 5);
`ifdef UCB_SCHED_FLIP_LIMIT_EN
      chk("budget_to_drain", sched_state, 2);
      ucb_req = '1;
      #1;
      chk("budget_no_gnt", ucb_gnt, 0);
      tick();
      ucb_req = '0;
      chk("budget_done", done, 1);
      max_flips = '0;
`else
      chk("no_budget_stays_run", sched_state, 1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      wait_done("drain_to_done_4");
`endif
      eng_flip = 2'b11;
      tick();
      eng_flip = '0;
      chk("done_flip_frozen_5", flip_total, 5);

      // Stop coincident with a grant, then reset during drain
      start = 1'b1;
      tick();
      start = 1'b0;
      ucb_req = 4'b0001;
      stop    = 1'b1;
      #1;
      chk("stop_with_gnt", ucb_gnt, 4'b0001);
      tick();
      stop = 1'b0;
      chk("stop_gnt_drain", sched_state, 2);
      chk("stop_gnt_valid", eng_valid, 2'b01);
      chk("stop_gnt_clause", eng_clause[CW-1:0], D0);
      #1;
      chk("drain_no_gnt", ucb_gnt, 0);
      eng_flip = 2'b01;
      tick();
      eng_flip = '0;
      chk("drain_counts_flip", flip_total, 1);
      rst_n = 1'b0;
      tick();
      #1;
      chk("rst2_gnt", ucb_gnt, 0);
      chk("rst2_valid", eng_valid, 0);
      chk("rst2_clause", eng_clause, 0);
      chk("rst2_flip", flip_total, 0);
      chk("rst2_state", sched_state, 0);
      chk("rst2_done", done, 0);
      rst_n   = 1'b1;
      ucb_req = '0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
